// File: rtl/slicer_error_gen.sv
`default_nettype none
// ============================================================================
//  Module      : slicer_error_gen
//  Description : Decision-directed error source for 4-ASK. Each symbol strobe
//                slices the received sample to the nearest of {-3a,-a,+a,+3a},
//                emits the saturated error (sample - level) with a Gray-coded
//                decision, and frames fixed 2^WIN_LOG2-symbol accumulation
//                windows with clear_accumulator / window_valid pulses.
//  Option      : define MAG_OUT_EN to add the mag_out port (|sample|,
//                saturated, registered alongside error).
//  Revision    : 1.0 - initial release
// ============================================================================
module slicer_error_gen #(
  parameter int DATA_WIDTH  = 18,
  parameter int WIN_LOG2    = 10,
  parameter int WARMUP_SYMS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         sym_clk_ena,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] ref_a,
  output logic signed [DATA_WIDTH-1:0] error,
  output logic        [1:0]            decision,
  output logic                         sym_ena_out,
  output logic                         clear_accumulator,
  output logic                         window_valid,
  output logic        [1:0]            state_dbg
`ifdef MAG_OUT_EN
  ,
  output logic        [DATA_WIDTH-1:0] mag_out
`endif
);

  // Extended arithmetic width: sample minus a level up to 3a never overflows.
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_WARMUP = 2'b01;
  localparam logic [1:0] ST_RUN    = 2'b10;

  localparam logic [1:0] DEC_M3 = 2'b00;
  localparam logic [1:0] DEC_M1 = 2'b01;
  localparam logic [1:0] DEC_P1 = 2'b11;
  localparam logic [1:0] DEC_P3 = 2'b10;

  localparam int             WU_W    = (WARMUP_SYMS > 1) ? $clog2(WARMUP_SYMS) : 1;
  localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP_SYMS - 1);

  localparam logic signed [EW-1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {3'b111, {(DATA_WIDTH-1){1'b0}}};

  // --------------------------------------------------------------------------
  // Slicer datapath
  // --------------------------------------------------------------------------
  logic signed [DATA_WIDTH:0] two_a_n;
  logic signed [EW-1:0]       s_x;
  logic signed [EW-1:0]       a_x;
  logic signed [EW-1:0]       two_a_x;
  logic signed [EW-1:0]       neg_two_a_x;
  logic signed [EW-1:0]       three_a_x;
  logic signed [EW-1:0]       level_x;
  logic signed [EW-1:0]       diff_x;
  logic        [1:0]          dec_d;
  logic signed [DATA_WIDTH-1:0] err_d;

  // 2a is exact at DATA_WIDTH+1 bits: a left shift of the signed reference.
  assign two_a_n     = {ref_a, 1'b0};
  assign s_x         = {{2{sample[DATA_WIDTH-1]}}, sample};
  assign a_x         = {{2{ref_a[DATA_WIDTH-1]}}, ref_a};
  assign two_a_x     = {two_a_n[DATA_WIDTH], two_a_n};
  assign neg_two_a_x = -two_a_x;
  assign three_a_x   = a_x + two_a_x;

  // Nearest-level decision; each threshold belongs to the region above it.
  always_comb begin
    dec_d   = DEC_M3;
    level_x = -three_a_x;
    if (s_x >= two_a_x) begin
      dec_d   = DEC_P3;
      level_x = three_a_x;
    end else if (!s_x[EW-1]) begin
      dec_d   = DEC_P1;
      level_x = a_x;
    end else if (s_x >= neg_two_a_x) begin
      dec_d   = DEC_M1;
      level_x = -a_x;
    end
  end

  assign diff_x = s_x - level_x;

  // Clamp the wide difference back to DATA_WIDTH instead of wrapping.
  always_comb begin
    err_d = diff_x[DATA_WIDTH-1:0];
    if (diff_x > SAT_MAX) begin
      err_d = SAT_MAX[DATA_WIDTH-1:0];
    end else if (diff_x < SAT_MIN) begin
      err_d = SAT_MIN[DATA_WIDTH-1:0];
    end
  end

`ifdef MAG_OUT_EN
  logic signed [EW-1:0]       abs_x;
  logic [DATA_WIDTH-1:0]      mag_d;
  logic [DATA_WIDTH-1:0]      mag_q;

  assign abs_x = s_x[EW-1] ? -s_x : s_x;

  // |most-negative sample| does not fit, so it clamps to the positive maximum.
  always_comb begin
    mag_d = abs_x[DATA_WIDTH-1:0];
    if (abs_x > SAT_MAX) begin
      mag_d = SAT_MAX[DATA_WIDTH-1:0];
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control: IDLE -> WARMUP -> RUN, window framing
  // --------------------------------------------------------------------------
  logic [1:0]          state_q,     state_d;
  logic [WU_W-1:0]     warm_cnt_q,  warm_cnt_d;
  logic [WIN_LOG2-1:0] sym_cnt_q,   sym_cnt_d;
  logic                first_win_q, first_win_d;
  logic                clr_d;
  logic                wv_d;
  logic                accept_w;

  // Strobes count only once the machine has left IDLE and enable is still high;
  // a strobe coinciding with enable falling is dropped.
  assign accept_w = sym_clk_ena & enable & (state_q != ST_IDLE);

  // Next-state and window-pulse logic.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    first_win_d = first_win_q;
    clr_d       = 1'b0;
    wv_d        = 1'b0;
    if (!enable) begin
      state_d     = ST_IDLE;
      warm_cnt_d  = '0;
      sym_cnt_d   = '0;
      first_win_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_WARMUP;
          warm_cnt_d = '0;
          sym_cnt_d  = '0;
        end
        ST_WARMUP: begin
          if (sym_clk_ena) begin
            if (warm_cnt_q == WU_LAST) begin
              state_d    = ST_RUN;
              warm_cnt_d = '0;
              sym_cnt_d  = '0;
            end else begin
              warm_cnt_d = warm_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (sym_clk_ena) begin
            sym_cnt_d = sym_cnt_q + 1'b1;
            if (sym_cnt_q == '0) begin
              // The very first clear after (re)start opens window 0; nothing
              // complete has been accumulated before it.
              clr_d       = 1'b1;
              wv_d        = ~first_win_q;
              first_win_d = 1'b0;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      warm_cnt_q  <= '0;
      sym_cnt_q   <= '0;
      first_win_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      first_win_q <= first_win_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers: one clock of latency, error/decision hold between strobes
  // --------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] error_q;
  logic [1:0]                   decision_q;
  logic                         sym_ena_q;
  logic                         clr_q;
  logic                         wv_q;

  // Pulses are derived from the accepted strobe so they never outlive it.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q    <= '0;
      decision_q <= '0;
      sym_ena_q  <= 1'b0;
      clr_q      <= 1'b0;
      wv_q       <= 1'b0;
    end else begin
      sym_ena_q <= accept_w;
      clr_q     <= clr_d & accept_w;
      wv_q      <= wv_d & accept_w;
      if (accept_w) begin
        error_q    <= err_d;
        decision_q <= dec_d;
      end
    end
  end

`ifdef MAG_OUT_EN
  // Magnitude shares the error register's strobe and latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      mag_q <= '0;
    end else if (accept_w) begin
      mag_q <= mag_d;
    end
  end

  assign mag_out = mag_q;
`endif

  assign error             = error_q;
  assign decision          = decision_q;
  assign sym_ena_out       = sym_ena_q;
  assign clear_accumulator = clr_q;
  assign window_valid      = wv_q;
  assign state_dbg         = state_q;

endmodule
`default_nettype wire
